// File: rtl/fsm_dbg_pkg.sv
// Shared opcodes, control-state encodings and default widths for the debug run-control block.
package fsm_dbg_pkg;

  localparam int unsigned STATE_W_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 16;
  localparam int unsigned OP_W        = 3;
  localparam int unsigned CTRL_W      = 2;

  localparam logic [OP_W-1:0] OP_NOP     = 3'd0;
  localparam logic [OP_W-1:0] OP_HALT    = 3'd1;
  localparam logic [OP_W-1:0] OP_RUN     = 3'd2;
  localparam logic [OP_W-1:0] OP_STEP    = 3'd3;
  localparam logic [OP_W-1:0] OP_SET_BP  = 3'd4;
  localparam logic [OP_W-1:0] OP_CLR_BP  = 3'd5;
  localparam logic [OP_W-1:0] OP_CLR_CNT = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD    = 3'd7;

  localparam logic [CTRL_W-1:0] ST_HALT  = 2'd0;
  localparam logic [CTRL_W-1:0] ST_RUN   = 2'd1;
  localparam logic [CTRL_W-1:0] ST_STEP  = 2'd2;
  localparam logic [CTRL_W-1:0] ST_BREAK = 2'd3;

endpackage

// File: rtl/dbg_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module dbg_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fsm_debug_ctrl.sv
// Debug run-control sequencer: gates the FSM core's clock enable for HALT/RUN/STEP
// and parks the core on a breakpoint state.
module fsm_debug_ctrl
  import fsm_dbg_pkg::*;
#(
  parameter int unsigned STATE_W = STATE_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [CNT_W-1:0]   cmd_arg,
  input  logic [STATE_W-1:0] core_state,
  output logic               core_clk_enable,
  output logic               halted,
  output logic               bp_hit,
  output logic [CNT_W-1:0]   step_remaining,
  output logic [CNT_W-1:0]   cycle_count
);

  logic [CTRL_W-1:0]  st_q, st_d;
  logic               bp_en_q, bp_en_d;
  logic [STATE_W-1:0] bp_state_q, bp_state_d;
  logic               bp_skip_q, bp_skip_d;
  logic               bp_hit_q, bp_hit_d;
  logic [CNT_W-1:0]   step_rem_q, step_rem_d;

  logic cmd_acc;
  logic bp_match;
  logic clk_en;
  logic cnt_clr;

  // Enable depends only on registers and core_state, never on the command inputs.
  assign cmd_acc  = cmd_valid & cmd_ready;
  assign bp_match = bp_en_q & (core_state == bp_state_q) & ~bp_skip_q;
  assign clk_en   = ((st_q == ST_RUN) & ~bp_match) | (st_q == ST_STEP);
  assign cnt_clr  = cmd_acc & (cmd_op == OP_CLR_CNT);

  assign cmd_ready       = (st_q != ST_STEP);
  assign core_clk_enable = clk_en;
  assign halted          = (st_q == ST_HALT) | (st_q == ST_BREAK);
  assign bp_hit          = bp_hit_q;
  assign step_remaining  = step_rem_q;

  always_comb begin
    st_d       = st_q;
    bp_en_d    = bp_en_q;
    bp_state_d = bp_state_q;
    bp_skip_d  = bp_skip_q;
    bp_hit_d   = bp_hit_q;
    step_rem_d = step_rem_q;

    // Skip lets a RUN/STEP carry the core off a breakpoint it is parked on.
    if (clk_en) begin
      bp_skip_d = 1'b0;
    end
    if (cmd_acc && ((cmd_op == OP_RUN) || (cmd_op == OP_STEP))) begin
      bp_skip_d = 1'b1;
    end

    if (cmd_acc && (cmd_op == OP_SET_BP)) begin
      bp_state_d = cmd_arg[STATE_W-1:0];
      bp_en_d    = 1'b1;
    end else if (cmd_acc && (cmd_op == OP_CLR_BP)) begin
      bp_en_d = 1'b0;
    end

    case (st_q)
      ST_HALT, ST_BREAK: begin
        if (cmd_acc) begin
          if (cmd_op == OP_RUN) begin
            st_d     = ST_RUN;
            bp_hit_d = 1'b0;
          end else if (cmd_op == OP_STEP) begin
            st_d       = ST_STEP;
            bp_hit_d   = 1'b0;
            step_rem_d = (cmd_arg == '0) ? CNT_W'(1) : cmd_arg;
          end else if (cmd_op == OP_HALT) begin
            st_d     = ST_HALT;
            bp_hit_d = 1'b0;
          end
        end
      end
      ST_RUN: begin
        // A breakpoint outranks a simultaneous HALT so the host still sees bp_hit.
        if (bp_match) begin
          st_d     = ST_BREAK;
          bp_hit_d = 1'b1;
        end else if (cmd_acc && (cmd_op == OP_HALT)) begin
          st_d = ST_HALT;
        end
      end
      ST_STEP: begin
        if (step_rem_q <= CNT_W'(1)) begin
          st_d       = ST_HALT;
          step_rem_d = '0;
        end else begin
          step_rem_d = step_rem_q - CNT_W'(1);
        end
      end
      default: begin
        st_d = ST_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q       <= ST_HALT;
      bp_en_q    <= 1'b0;
      bp_state_q <= '0;
      bp_skip_q  <= 1'b0;
      bp_hit_q   <= 1'b0;
      step_rem_q <= '0;
    end else begin
      st_q       <= st_d;
      bp_en_q    <= bp_en_d;
      bp_state_q <= bp_state_d;
      bp_skip_q  <= bp_skip_d;
      bp_hit_q   <= bp_hit_d;
      step_rem_q <= step_rem_d;
    end
  end

  dbg_sat_counter #(
    .W(CNT_W)
  ) u_cycle_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (cnt_clr),
    .inc_i  (clk_en),
    .count_o(cycle_count)
  );

endmodule

// File: tb/tb_fsm_debug_ctrl.sv
// Bench for fsm_debug_ctrl: directed run-control scenarios plus random commands against a
// behavioural model of the controller and a toy FSM core.
module tb_fsm_debug_ctrl;
  import fsm_dbg_pkg::*;

  localparam int unsigned SW  = 4;
  localparam int unsigned CW  = 16;
  localparam int unsigned SCW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b0;
  logic           cmd_valid = 1'b0;
  logic [2:0]     cmd_op = 3'd0;
  logic [CW-1:0]  cmd_arg = '0;
  logic [SW-1:0]  core_state = '0;
  logic           cmd_ready, core_clk_enable, halted, bp_hit;
  logic [CW-1:0]  step_remaining, cycle_count;

  // narrow-counter instance used for saturation checks
  logic           s_valid = 1'b0;
  logic [2:0]     s_op = 3'd0;
  logic [SCW-1:0] s_arg = '0;
  logic [SW-1:0]  s_core = '0;
  logic           s_ready, s_en, s_halted, s_bp_hit;
  logic [SCW-1:0] s_rem, s_count;

  fsm_debug_ctrl #(.STATE_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .core_state(core_state),
    .core_clk_enable(core_clk_enable), .halted(halted), .bp_hit(bp_hit),
    .step_remaining(step_remaining), .cycle_count(cycle_count)
  );

  fsm_debug_ctrl #(.STATE_W(SW), .CNT_W(SCW)) dut_s (
    .clk(clk), .reset(reset), .cmd_valid(s_valid), .cmd_ready(s_ready),
    .cmd_op(s_op), .cmd_arg(s_arg), .core_state(s_core),
    .core_clk_enable(s_en), .halted(s_halted), .bp_hit(s_bp_hit),
    .step_remaining(s_rem), .cycle_count(s_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int         x_in = 0;
  logic       core_jump = 1'b0;
  logic [3:0] core_jump_val = 4'd0;

  // model: mode 0 = stopped (halt or break), 1 = running, 2 = stepping
  int m_mode   = 0;
  int m_steps  = 0;
  int m_count  = 0;
  int m_bp_st  = 0;
  bit m_bp_en  = 1'b0;
  bit m_skip   = 1'b0;
  bit m_bp_hit = 1'b0;

  bit m_hit_w, m_en_w, m_acc_w;
  assign m_hit_w = m_bp_en && (int'(core_state) == m_bp_st) && !m_skip;
  assign m_en_w  = ((m_mode == 1) && !m_hit_w) || (m_mode == 2);
  assign m_acc_w = cmd_valid && (m_mode != 2);

  function automatic logic [3:0] core_next(logic [3:0] s, int x);
    case (x)
      0:       return s;
      1:       return s + 4'd1;
      2:       return 4'd1;
      default: return (s == 4'd0) ? 4'd2 : ((s == 4'd2) ? 4'd4 : 4'd0);
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= 0; m_steps <= 0; m_count <= 0; m_bp_st <= 0;
      m_bp_en <= 1'b0; m_skip <= 1'b0; m_bp_hit <= 1'b0;
    end else begin
      if (core_jump) core_state <= core_jump_val;
      else if (m_en_w) core_state <= core_next(core_state, x_in);

      if (m_acc_w && cmd_op == OP_CLR_CNT) m_count <= 0;
      else if (m_en_w && m_count < 65535) m_count <= m_count + 1;

      if (m_acc_w && (cmd_op == OP_RUN || cmd_op == OP_STEP)) m_skip <= 1'b1;
      else if (m_en_w) m_skip <= 1'b0;

      if (m_acc_w && cmd_op == OP_SET_BP) begin
        m_bp_st <= int'(cmd_arg) % 16;
        m_bp_en <= 1'b1;
      end else if (m_acc_w && cmd_op == OP_CLR_BP) begin
        m_bp_en <= 1'b0;
      end

      if (m_mode == 2) begin
        m_steps <= m_steps - 1;
        if (m_steps == 1) m_mode <= 0;
      end else if (m_mode == 1) begin
        if (m_hit_w) begin
          m_mode <= 0; m_bp_hit <= 1'b1;
        end else if (m_acc_w && cmd_op == OP_HALT) begin
          m_mode <= 0;
        end
      end else if (m_acc_w) begin
        if (cmd_op == OP_RUN) begin
          m_mode <= 1; m_bp_hit <= 1'b0;
        end else if (cmd_op == OP_STEP) begin
          m_mode <= 2; m_bp_hit <= 1'b0;
          m_steps <= (cmd_arg == '0) ? 1 : int'(cmd_arg);
        end else if (cmd_op == OP_HALT) begin
          m_bp_hit <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("cmd_ready", int'(cmd_ready), (m_mode != 2) ? 1 : 0);
    chk("core_clk_enable", int'(core_clk_enable), int'(m_en_w));
    chk("halted", int'(halted), (m_mode == 0) ? 1 : 0);
    chk("bp_hit", int'(bp_hit), int'(m_bp_hit));
    chk("step_remaining", int'(step_remaining), (m_mode == 2) ? m_steps : 0);
    chk("cycle_count", int'(cycle_count), m_count);
  endtask

  // one cycle: compare on the falling edge, return just after the next rising edge
  task automatic tick();
    @(negedge clk);
    if (reset) compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input int arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = CW'(arg);
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
  endtask

  task automatic jump_core(input logic [3:0] v);
    core_jump = 1'b1;
    core_jump_val = v;
    tick();
    core_jump = 1'b0;
  endtask

  logic [2:0] op_tbl [11];
  int exp_rem [6];

  initial begin
    int n;
    int c0;
    int rec [6];
    op_tbl = '{OP_NOP, OP_HALT, OP_RUN, OP_RUN, OP_STEP, OP_STEP,
               OP_SET_BP, OP_SET_BP, OP_CLR_BP, OP_CLR_CNT, OP_RSVD};
    exp_rem = '{5, 4, 3, 2, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_halted", int'(halted), 1);
    chk("rst_enable", int'(core_clk_enable), 0);
    chk("rst_count", int'(cycle_count), 0);
    chk("rst_bp_hit", int'(bp_hit), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_step_rem", int'(step_remaining), 0);
    reset = 1'b1;
    tick();

    // saturation and clear-over-increment on the 4-bit counter
    s_valid = 1'b1; s_op = OP_RUN;
    tick();
    s_valid = 1'b0;
    repeat (20) tick();
    chk("sat_count", int'(s_count), 15);
    chk("sat_enable", int'(s_en), 1);
    s_valid = 1'b1; s_op = OP_CLR_CNT;
    tick();
    s_valid = 1'b0;
    chk("clr_beats_inc", int'(s_count), 0);
    repeat (3) tick();
    chk("count_after_clr", int'(s_count), 3);
    s_valid = 1'b1; s_op = OP_HALT;
    tick();
    s_valid = 1'b0;
    chk("s_halted", int'(s_halted), 1);

    // breakpoint on state 4 with core walking 0,2,4
    x_in = 3;
    send(OP_SET_BP, 4);
    send(OP_RUN, 0);
    for (int i = 0; i < 20; i++) begin
      if (halted) break;
      tick();
    end
    chk("break_reached", int'(halted), 1);
    chk("break_core", int'(core_state), 4);
    chk("break_bp_hit", int'(bp_hit), 1);
    chk("break_count", int'(cycle_count), 2);
    chk("break_enable", int'(core_clk_enable), 0);

    send(OP_STEP, 1);
    chk("step1_ready", int'(cmd_ready), 0);
    chk("step1_enable", int'(core_clk_enable), 1);
    chk("step1_rem", int'(step_remaining), 1);
    tick();
    chk("step1_halted", int'(halted), 1);
    chk("step1_bp_hit", int'(bp_hit), 0);
    chk("step1_count", int'(cycle_count), 3);
    chk("step1_core", int'(core_state), 0);
    chk("step1_ready_back", int'(cmd_ready), 1);

    // STEP 0 behaves as STEP 1
    x_in = 1;
    send(OP_STEP, 0);
    n = 0;
    repeat (6) begin
      n += int'(core_clk_enable);
      tick();
    end
    chk("step0_pulses", n, 1);

    // STEP 5 with the command held valid throughout
    cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_arg = CW'(5);
    tick();
    n = 0;
    for (int i = 0; i < 6; i++) begin
      rec[i] = int'(step_remaining);
      n += int'(core_clk_enable);
      if (i < 5) tick();
    end
    cmd_valid = 1'b0; cmd_op = OP_NOP;
    repeat (3) begin
      tick();
      n += int'(core_clk_enable);
    end
    for (int i = 0; i < 6; i++) chk("step5_rem_seq", rec[i], exp_rem[i]);
    chk("step5_pulses", n, 5);
    chk("step5_halted", int'(halted), 1);

    // parked on the breakpoint state: one enable via skip, then break
    x_in = 2;
    send(OP_STEP, 1);
    tick();
    chk("park_core", int'(core_state), 1);
    x_in = 0;
    send(OP_SET_BP, 1);
    c0 = int'(cycle_count);
    send(OP_RUN, 0);
    chk("park_skip_enable", int'(core_clk_enable), 1);
    tick();
    chk("park_match_enable", int'(core_clk_enable), 0);
    chk("park_not_yet_halted", int'(halted), 0);
    tick();
    chk("park_halted", int'(halted), 1);
    chk("park_bp_hit", int'(bp_hit), 1);
    chk("park_count", int'(cycle_count), c0 + 1);
    send(OP_HALT, 0);
    chk("halt_clears_bp_hit", int'(bp_hit), 0);

    // asynchronous reset in the middle of a run
    jump_core(4'd5);
    x_in = 1;
    send(OP_SET_BP, 0);
    send(OP_RUN, 0);
    tick();
    tick();
    chk("pre_rst_enable", int'(core_clk_enable), 1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_enable", int'(core_clk_enable), 0);
    chk("midrst_halted", int'(halted), 1);
    chk("midrst_count", int'(cycle_count), 0);
    chk("midrst_bp_hit", int'(bp_hit), 0);
    chk("midrst_ready", int'(cmd_ready), 1);
    tick();
    reset = 1'b1;
    jump_core(4'd0);
    x_in = 0;
    send(OP_RUN, 0);
    repeat (3) tick();
    chk("bp_cleared_by_rst", int'(halted), 0);
    send(OP_HALT, 0);

    // random commands against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        #2 reset = 1'b0;
        #1 chk("rnd_rst_enable", int'(core_clk_enable), 0);
        tick();
        reset = 1'b1;
      end
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_op    = op_tbl[$urandom_range(0, 10)];
      cmd_arg   = CW'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) cmd_arg = cmd_arg | CW'(16);
      x_in = int'($urandom_range(0, 3));
      tick();
    end
    cmd_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
